// File: rtl/inter_switch_sched_if.sv
// -----------------------------------------------------------------------------
// inter_switch_sched_if
// Descriptor stream into the switch scheduler (AXI-Stream style handshake).
//   s_desc_tdata  : descriptor {out_len, in_len, route[17:0]}
//   s_desc_tvalid : producer has a descriptor
//   s_desc_tready : scheduler queue can take it this cycle
// Modports: master = descriptor producer, slave = scheduler.
// -----------------------------------------------------------------------------
interface inter_switch_sched_if #(
   parameter int LEN_W = 16
) ();
   logic [18+2*LEN_W-1:0] s_desc_tdata;
   logic                  s_desc_tvalid;
   logic                  s_desc_tready;

   modport master (
      output s_desc_tdata,
      output s_desc_tvalid,
      input  s_desc_tready
   );

   modport slave (
      input  s_desc_tdata,
      input  s_desc_tvalid,
      output s_desc_tready
   );
endinterface

// File: rtl/inter_switch_sched.sv
// -----------------------------------------------------------------------------
// inter_switch_sched
// Queues switch transfer descriptors and sequences one transfer at a time:
// validate, settle the crossbar with all paths disabled (SETUP), enable the
// route and count beats (RUN/DRAIN), then pulse done.
//
// Ports
//   clk, rst_n  : clock, synchronous active-low reset
//   s_desc      : descriptor stream (slave modport of inter_switch_sched_if)
//   ctrl[17:0]  : switch control {shift_reg, shift_ctrl, dst, src}
//   in_beat     : accepted beat on the selected source
//   out_beat    : accepted beat on the selected destination
//   busy        : FSM not in IDLE
//   done        : one-cycle pulse on transfer completion
//   err         : one-cycle pulse on rejected descriptor / overrun beat
// -----------------------------------------------------------------------------
module inter_switch_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   inter_switch_sched_if.slave       s_desc,
   output logic [17:0]               ctrl,
   input  logic                      in_beat,
   input  logic                      out_beat,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int DW = 18 + 2*LEN_W;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------- queue
   logic [DW-1:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             r_rdy;     // low during reset, high from the cycle after
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [DW-1:0]    w_head;
   logic [17:0]      w_h_route;
   logic [LEN_W-1:0] w_h_in;
   logic [LEN_W-1:0] w_h_out;
   logic             w_h_valid;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

   // A pop this cycle frees a slot, so a full queue can still take a push.
   assign s_desc.s_desc_tready = r_rdy & (~w_full | w_pop);
   assign w_push = s_desc.s_desc_tvalid & s_desc.s_desc_tready;

   assign w_head    = r_mem[r_rptr[AW-1:0]];
   assign w_h_route = w_head[17:0];
   assign w_h_in    = w_head[LEN_W+17:18];
   assign w_h_out   = w_head[2*LEN_W+17:LEN_W+18];
   assign w_h_valid = (w_h_route[2:0] != 3'd0) && (w_h_route[2:0] <= 3'd5) &&
                      (w_h_in != '0) && (w_h_out != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_rdy  <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset; the pointers define what is live.
   always_ff @(posedge clk) begin
      if (rst_n && w_push) r_mem[r_wptr[AW-1:0]] <= s_desc.s_desc_tdata;
   end

   // ---------------------------------------------------------------- FSM
   state_t           r_state;
   state_t           w_state_nxt;
   logic [17:0]      r_route;
   logic [LEN_W-1:0] r_in_len;
   logic [LEN_W-1:0] r_out_len;
   logic [LEN_W-1:0] r_in_cnt;
   logic [LEN_W-1:0] r_out_cnt;
   logic [17:0]      r_ctrl;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_latch;
   logic             w_in_inc;
   logic             w_out_inc;
   logic             w_err_nxt;
   logic [17:0]      w_ctrl_nxt;
   logic             w_in_last;
   logic             w_out_last;
   logic             w_out_full;

   assign w_in_last  = (r_in_cnt  == r_in_len  - ONE);
   assign w_out_last = (r_out_cnt == r_out_len - ONE);
   assign w_out_full = (r_out_cnt == r_out_len);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_latch     = 1'b0;
      w_in_inc    = 1'b0;
      w_out_inc   = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_h_valid) begin
                  w_latch     = 1'b1;
                  w_state_nxt = S_SETUP;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_SETUP: w_state_nxt = S_RUN;
         S_RUN: begin
            if (out_beat) begin
               if (w_out_full) w_err_nxt = 1'b1;   // overrun: saturate
               else            w_out_inc = 1'b1;
            end
            if (in_beat) begin
               w_in_inc = 1'b1;
               if (w_in_last) begin
                  // Output side already complete, or completing this cycle.
                  if (w_out_full || (out_beat && w_out_last))
                     w_state_nxt = S_DONE;
                  else
                     w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (in_beat) w_err_nxt = 1'b1;         // input already complete
            if (out_beat) begin
               if (w_out_full) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_out_inc = 1'b1;
                  if (w_out_last) w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_comb begin
      w_ctrl_nxt = '0;
      case (w_state_nxt)
         S_SETUP:         w_ctrl_nxt = {w_h_route[17:3], 3'b000};
         S_RUN, S_DRAIN:  w_ctrl_nxt = r_route;
         default:         w_ctrl_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_route   <= '0;
         r_in_len  <= '0;
         r_out_len <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
         r_ctrl    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ctrl  <= w_ctrl_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= (w_state_nxt == S_DONE);
         r_err   <= w_err_nxt;
         if (w_latch) begin
            r_route   <= w_h_route;
            r_in_len  <= w_h_in;
            r_out_len <= w_h_out;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
         end else begin
            if (w_in_inc)  r_in_cnt  <= r_in_cnt  + ONE;
            if (w_out_inc) r_out_cnt <= r_out_cnt + ONE;
         end
      end
   end

   assign ctrl = r_ctrl;
   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

endmodule

// File: tb/tb_inter_switch_sched.sv
// -----------------------------------------------------------------------------
// tb_inter_switch_sched
// Directed stimulus; expected ctrl changes / err / done pulses are queued as
// each scenario is issued, and a negedge monitor pops and compares whenever
// the DUT shows one. Cycle-exact points are checked inline.
// -----------------------------------------------------------------------------
module tb_inter_switch_sched;
   localparam int LEN_W      = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int EV_CTRL    = 0;
   localparam int EV_ERR     = 1;
   localparam int EV_DONE    = 2;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        in_beat  = 1'b0;
   logic        out_beat = 1'b0;
   logic [17:0] ctrl;
   logic        busy;
   logic        done;
   logic        err;

   inter_switch_sched_if #(.LEN_W(LEN_W)) u_if ();

   inter_switch_sched #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_desc   (u_if),
      .ctrl     (ctrl),
      .in_beat  (in_beat),
      .out_beat (out_beat),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [17:0] val;
   } ev_t;

   ev_t         exp_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [17:0] prev_ctrl = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic expect_ev(input int kind, input logic [17:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic mon_ev(input int kind, input logic [17:0] val);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: got kind %0d val %0h expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind == kind && e.val === val) n_pass++;
         else $display("FAIL event_%0d: got kind %0d val %0h expected kind %0d val %0h",
                       n_chk, kind, val, e.kind, e.val);
      end
   endtask

   // Monitor: one event per ctrl change, per err-high cycle, per done-high cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (ctrl !== prev_ctrl) begin
            mon_ev(EV_CTRL, ctrl);
            prev_ctrl = ctrl;
         end
         if (err === 1'b1)  mon_ev(EV_ERR, '0);
         if (done === 1'b1) mon_ev(EV_DONE, '0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [18+2*LEN_W-1:0] mk(input logic [17:0] r,
                                                 input logic [LEN_W-1:0] il,
                                                 input logic [LEN_W-1:0] ol);
      return {ol, il, r};
   endfunction

   task automatic push_desc(input logic [17:0] r, input logic [LEN_W-1:0] il,
                            input logic [LEN_W-1:0] ol);
      u_if.s_desc_tdata  = mk(r, il, ol);
      u_if.s_desc_tvalid = 1'b1;
      tick();
      u_if.s_desc_tvalid = 1'b0;
   endtask

   initial begin
      logic seen_busy;
      logic seen_ctrl;
      u_if.s_desc_tdata  = '0;
      u_if.s_desc_tvalid = 1'b0;

      // ---- reset state
      repeat (3) tick();
      chk("rst_ctrl",  ctrl, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_err",   err,  0);
      chk("rst_tready", u_if.s_desc_tready, 0);
      rst_n = 1'b1;
      tick();
      chk("tready_after_rst", u_if.s_desc_tready, 1);
      tick();

      // ---- basic transfer: in_len=1, out_len=12
      expect_ev(EV_CTRL, 18'h00008);
      expect_ev(EV_CTRL, 18'h0000C);
      expect_ev(EV_CTRL, 18'h00000);
      expect_ev(EV_DONE, '0);
      push_desc(18'h0000C, 1, 12);
      tick();
      chk("t1_setup_ctrl", ctrl, 18'h00008);
      chk("t1_setup_busy", busy, 1);
      tick();
      chk("t1_run_ctrl", ctrl, 18'h0000C);
      in_beat = 1'b1; tick(); in_beat = 1'b0;
      out_beat = 1'b1;
      repeat (11) tick();
      chk("t1_no_early_done", done, 0);
      chk("t1_drain_ctrl", ctrl, 18'h0000C);
      tick();
      out_beat = 1'b0;
      chk("t1_done", done, 1);
      chk("t1_done_ctrl", ctrl, 0);
      tick();
      chk("t1_done_1cyc", done, 0);
      chk("t1_idle_busy", busy, 0);
      repeat (2) tick();

      // ---- rejected descriptors: src=0, src=6, in_len=0
      repeat (3) expect_ev(EV_ERR, '0);
      u_if.s_desc_tvalid = 1'b1;
      u_if.s_desc_tdata  = mk(18'h00008, 1, 1); tick();
      u_if.s_desc_tdata  = mk(18'h0000E, 1, 1); tick();
      u_if.s_desc_tdata  = mk(18'h00001, 0, 1); tick();
      u_if.s_desc_tvalid = 1'b0;
      seen_busy = 1'b0;
      seen_ctrl = 1'b0;
      repeat (6) begin
         seen_busy |= busy;
         seen_ctrl |= (ctrl != 18'h0);
         tick();
      end
      chk("t2_never_busy", seen_busy, 0);
      chk("t2_ctrl_zero", seen_ctrl, 0);

      // ---- queue fill while stalled in RUN; 5th push held until first pop
      expect_ev(EV_CTRL, 18'h00010);
      expect_ev(EV_CTRL, 18'h00011);
      expect_ev(EV_CTRL, 18'h00000);
      expect_ev(EV_DONE, '0);
      repeat (5) expect_ev(EV_ERR, '0);
      push_desc(18'h00011, 1, 1);
      tick();
      tick();
      chk("t3_run_ctrl", ctrl, 18'h00011);
      for (int k = 0; k < 4; k++) begin
         u_if.s_desc_tdata  = mk(18'h00008, 1, 1);
         u_if.s_desc_tvalid = 1'b1;
         tick();
      end
      chk("t3_full_tready", u_if.s_desc_tready, 0);
      u_if.s_desc_tdata = mk(18'h0000F, 1, 1);
      repeat (2) tick();
      chk("t3_held_tready", u_if.s_desc_tready, 0);
      in_beat = 1'b1; out_beat = 1'b1; tick(); in_beat = 1'b0; out_beat = 1'b0;
      chk("t3_done", done, 1);
      chk("t3_done_tready", u_if.s_desc_tready, 0);
      tick();
      chk("t3_pop_tready", u_if.s_desc_tready, 1);
      tick();
      u_if.s_desc_tvalid = 1'b0;
      repeat (7) tick();

      // ---- paired beats: final in+out goes straight to DONE
      expect_ev(EV_CTRL, 18'h00018);
      expect_ev(EV_CTRL, 18'h0001A);
      expect_ev(EV_CTRL, 18'h00000);
      expect_ev(EV_DONE, '0);
      push_desc(18'h0001A, 2, 2);
      tick();
      tick();
      chk("t4_run_ctrl", ctrl, 18'h0001A);
      in_beat = 1'b1; out_beat = 1'b1;
      tick();
      chk("t4_mid_done", done, 0);
      tick();
      in_beat = 1'b0; out_beat = 1'b0;
      chk("t4_skip_drain_done", done, 1);
      chk("t4_done_ctrl", ctrl, 0);
      repeat (2) tick();

      // ---- extra in_beat in DRAIN
      expect_ev(EV_CTRL, 18'h15A40);
      expect_ev(EV_CTRL, 18'h15A45);
      expect_ev(EV_ERR,  '0);
      expect_ev(EV_CTRL, 18'h00000);
      expect_ev(EV_DONE, '0);
      push_desc(18'h15A45, 1, 2);
      tick();
      chk("t5_setup_ctrl", ctrl, 18'h15A40);
      tick();
      in_beat = 1'b1; tick();
      chk("t5_drain_busy", busy, 1);
      tick(); in_beat = 1'b0;
      chk("t5_drain_err", err, 1);
      out_beat = 1'b1; tick();
      chk("t5_no_early_done", done, 0);
      tick(); out_beat = 1'b0;
      chk("t5_done", done, 1);
      repeat (2) tick();

      // ---- beats ignored in IDLE/SETUP; out_beat overrun in RUN
      in_beat = 1'b1; out_beat = 1'b1; tick(); in_beat = 1'b0; out_beat = 1'b0;
      expect_ev(EV_CTRL, 18'h00010);
      expect_ev(EV_CTRL, 18'h00011);
      expect_ev(EV_ERR,  '0);
      expect_ev(EV_CTRL, 18'h00000);
      expect_ev(EV_DONE, '0);
      push_desc(18'h00011, 1, 1);
      in_beat = 1'b1; out_beat = 1'b1;
      tick();
      tick();
      in_beat = 1'b0; out_beat = 1'b0;
      chk("t6_run_ctrl", ctrl, 18'h00011);
      out_beat = 1'b1; tick();
      chk("t6_no_err_first", err, 0);
      tick(); out_beat = 1'b0;
      chk("t6_overrun_err", err, 1);
      in_beat = 1'b1; tick(); in_beat = 1'b0;
      chk("t6_done", done, 1);
      repeat (2) tick();

      // ---- reset mid-RUN with 2 queued descriptors
      expect_ev(EV_CTRL, 18'h00010);
      expect_ev(EV_CTRL, 18'h00011);
      expect_ev(EV_CTRL, 18'h00000);
      u_if.s_desc_tdata  = mk(18'h00011, 3, 3);
      u_if.s_desc_tvalid = 1'b1;
      repeat (3) tick();
      u_if.s_desc_tvalid = 1'b0;
      tick();
      chk("t7_run_ctrl", ctrl, 18'h00011);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("t7_rst_ctrl", ctrl, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_tready", u_if.s_desc_tready, 0);
      tick();
      chk("t7_tready_back", u_if.s_desc_tready, 1);
      seen_busy = 1'b0;
      repeat (6) begin
         seen_busy |= busy;
         tick();
      end
      chk("t7_queue_empty", seen_busy, 0);

      repeat (2) tick();
      chk("events_left", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/inter_switch_sched.md
INTER_SWITCH_SCHED -- requirements
Module: inter_switch_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, descriptor queue depth (power of 2, >=2).
REQ-002 SHALL have parameter LEN_W, default 16, beat-counter and length-field width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_desc_tdata  input  18+2*LEN_W  descriptor: [17:0] route word, [LEN_W+17:18] in_len, [2*LEN_W+17:LEN_W+18] out_len.
REQ-006 SHALL have port s_desc_tvalid  input  1  descriptor valid.
REQ-007 SHALL have port s_desc_tready  output  1  high when the queue is not full.
REQ-008 SHALL have port ctrl  output  18  switch control word: [2:0] source, [5:3] destination, [8:6] shift_ctrl, [17:9] shift_reg.
REQ-009 SHALL have port in_beat  input  1  one pulse per accepted beat on the selected source.
REQ-010 SHALL have port out_beat  input  1  one pulse per accepted beat on the selected destination.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on transfer completion.
REQ-013 SHALL have port err  output  1  one-cycle pulse on a rejected descriptor or an overrun.

Function
REQ-014 Queue: FIFO, FIFO_DEPTH entries; push on s_desc_tvalid & s_desc_tready; a push to an empty queue is visible to the FSM on the next cycle.
REQ-015 The queue SHALL accept a simultaneous push and pop when full.
REQ-016 FSM states are IDLE, SETUP, RUN, DRAIN and DONE; state is registered; all outputs are registered.
REQ-017 IDLE: ctrl=0; with the queue non-empty, pop the head and validate it.
REQ-018 Valid descriptor: ctrl[2:0] in 1..5, in_len!=0 and out_len!=0.
REQ-019 Invalid descriptor: pulse err the next cycle, discard it, stay in IDLE; no ctrl change.
REQ-020 Valid descriptor: latch it, go to SETUP, and clear in_cnt and out_cnt.
REQ-021 SETUP (exactly 1 cycle): ctrl = {latched[17:3], 3'b000}, so destination and shift settle while all paths are disabled; then go to RUN.
REQ-022 RUN: ctrl = latched[17:0]; in_cnt increments on in_beat; out_cnt increments on out_beat.
REQ-023 On in_beat with in_cnt==in_len-1: go to DRAIN, or to DONE if out_cnt has reached or is reaching out_len in the same cycle.
REQ-024 DRAIN: ctrl held; out_cnt counts; in_beat here pulses err, is not counted, and the state is unchanged.
REQ-025 On out_beat with out_cnt==out_len-1 in DRAIN: go to DONE.
REQ-026 out_beat when out_cnt==out_len already (RUN or DRAIN): pulse err; out_cnt saturates; no state change.
REQ-027 DONE (exactly 1 cycle): done=1, ctrl=0; next state is IDLE.
REQ-028 From DONE to RUN of the next queued descriptor takes a minimum of 3 cycles (IDLE pop, SETUP, RUN).
REQ-029 Counters are LEN_W bits; lengths up to 2^LEN_W-1 are supported; no wrap.
REQ-030 in_beat and out_beat are ignored in IDLE, SETUP and DONE.
REQ-031 An ignored beat in IDLE, SETUP or DONE raises no err.
REQ-032 done and err may assert in the same cycle.

Reset
REQ-033 While rst_n=0 at a clock edge: state=IDLE, queue empty, counters 0, ctrl=0, busy=0, done=0, err=0.
REQ-034 While rst_n=0, s_desc_tready=0; it returns to 1 the cycle after reset deasserts.
REQ-035 Reset mid-transfer abandons the transfer with no done pulse.
REQ-036 Reset mid-transfer discards all queued descriptors.

Verification
REQ-037 Scenario: push {ctrl=18'h0000C, in_len=1, out_len=12}, 1 in_beat in RUN, then 12 out_beat -> SETUP ctrl=18'h00008; RUN ctrl=18'h0000C; done 1 cycle after the 12th out_beat; ctrl=0.
REQ-038 Scenario: push ctrl[2:0]=0, then ctrl[2:0]=6, then in_len=0 -> 3 err pulses; ctrl stays 0; busy never high.
REQ-039 Scenario: 5 pushes back-to-back with FIFO_DEPTH=4 and the FSM stalled in RUN -> s_desc_tready low after the 4th push; the 5th is held until the first pop.
REQ-040 Scenario: in_len=2, out_len=2, beats paired each cycle -> the final simultaneous in_beat+out_beat goes RUN->DONE directly, skipping DRAIN.
REQ-041 Scenario: extra in_beat in DRAIN, and an out_beat after out_len is reached -> err each time; counts and done timing unchanged.
REQ-042 Scenario: rst_n=0 for 1 cycle mid-RUN with 2 queued descriptors -> next cycle ctrl=0, busy=0, s_desc_tready=0; no done; the queue is empty afterwards.
